// File: rtl/lcd_timing_controller_if.sv
// ----------------------------------------------------------------------------
// lcd_timing_controller_if
//
// Bundles the control, status and interrupt signals of the LCD timing
// controller.
//
//   master : the timing controller itself. It drives the counters, mode,
//            pulses and flags, and receives enable, render status, the LYC
//            compare value and the STAT enables.
//   slave  : the consumer side (CPU register file / renderer / bench). It
//            drives the controls and observes the timing outputs.
//
// Signals
//   lcd_enable     LCDC.7; low holds the controller idle
//   renderComplete renderer finished the current line
//   lyc[7:0]       LY compare value
//   stat_ie[3:0]   STAT enables: [0] HBlank, [1] VBlank, [2] OAM, [3] LYC
//   drawline       one-cycle pulse that starts pixel transfer
//   ly[7:0]        current line
//   dot[8:0]       current dot within the line
//   mode[1:0]      0 HBlank, 1 VBlank, 2 OAM search, 3 pixel transfer
//   lyc_match      ly == lyc
//   vblank_irq     one-cycle pulse on VBlank entry
//   stat_irq       one-cycle pulse on a rising STAT line
//   frame_done     one-cycle pulse on the last dot of the last line
//   render_timeout sticky flag: pixel transfer was forced to end
// ----------------------------------------------------------------------------
interface lcd_timing_controller_if;
    logic       lcd_enable;
    logic       renderComplete;
    logic [7:0] lyc;
    logic [3:0] stat_ie;

    logic       drawline;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       lyc_match;
    logic       vblank_irq;
    logic       stat_irq;
    logic       frame_done;
    logic       render_timeout;

    modport master (
        input  lcd_enable,
        input  renderComplete,
        input  lyc,
        input  stat_ie,
        output drawline,
        output ly,
        output dot,
        output mode,
        output lyc_match,
        output vblank_irq,
        output stat_irq,
        output frame_done,
        output render_timeout
    );

    modport slave (
        output lcd_enable,
        output renderComplete,
        output lyc,
        output stat_ie,
        input  drawline,
        input  ly,
        input  dot,
        input  mode,
        input  lyc_match,
        input  vblank_irq,
        input  stat_irq,
        input  frame_done,
        input  render_timeout
    );
endinterface

// File: rtl/lcd_timing_controller.sv
// ----------------------------------------------------------------------------
// lcd_timing_controller
//
// Scanline and frame sequencer for the whizgraphics renderer. Owns the dot
// and line counters, steps the LCD modes (OAM search, pixel transfer, HBlank,
// VBlank), issues one drawline pulse per visible line and waits for
// renderComplete to close pixel transfer. Also produces LY, the LYC match
// flag and the VBlank / STAT interrupt pulses.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    lcd_timing_controller_if.master (controls in, timing/irqs out)
//
// All outputs except stat_irq are registered. stat_irq is the rising edge of
// the STAT line, which is itself a function of registered mode / lyc_match
// and the live STAT enables, so it lines up with the cycle whose registered
// state raised the condition.
// ----------------------------------------------------------------------------
module lcd_timing_controller #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned LINES_VISIBLE = 144,
    parameter int unsigned LINES_TOTAL   = 154,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned MAX_DRAW_DOTS = 289
) (
    input  logic                          clk,
    input  logic                          reset,
    lcd_timing_controller_if.master       bus
);

    localparam logic [8:0] DOT_LAST     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_OAM_END  = 9'(OAM_DOTS);
    localparam logic [8:0] DOT_DRAW_END = 9'(OAM_DOTS + MAX_DRAW_DOTS);
    localparam logic [7:0] LY_VBLANK    = 8'(LINES_VISIBLE);
    localparam logic [7:0] LY_LAST      = 8'(LINES_TOTAL - 1);

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_DRAW   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       running_q;      // high once the enable edge has been taken
    logic [8:0] dot_q,  dot_d;
    logic [7:0] ly_q,   ly_d;
    logic [1:0] mode_q, mode_d;
    logic       drawline_q,       drawline_d;
    logic       lyc_match_q,      lyc_match_d;
    logic       vblank_irq_q,     vblank_irq_d;
    logic       frame_done_q,     frame_done_d;
    logic       render_timeout_q, render_timeout_d;
    logic       stat_line_q,      stat_line_d;
    logic       stat_line;

    // ------------------------------------------------------------------
    // Counters and mode sequencing
    // ------------------------------------------------------------------
    always_comb begin
        dot_d            = dot_q;
        ly_d             = ly_q;
        mode_d           = mode_q;
        drawline_d       = 1'b0;
        render_timeout_d = render_timeout_q;

        if (!bus.lcd_enable) begin
            dot_d  = '0;
            ly_d   = '0;
            mode_d = MODE_HBLANK;
        end else if (!running_q) begin
            // First enabled edge: start of line 0, OAM search.
            dot_d  = '0;
            ly_d   = '0;
            mode_d = MODE_OAM;
        end else if (dot_q == DOT_LAST) begin
            // Line wrap. Line length never depends on render time.
            dot_d  = '0;
            ly_d   = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
            mode_d = (ly_d < LY_VBLANK) ? MODE_OAM : MODE_VBLANK;
        end else begin
            dot_d = dot_q + 9'd1;
            case (mode_q)
                MODE_OAM: begin
                    if (dot_d == DOT_OAM_END) begin
                        mode_d     = MODE_DRAW;
                        drawline_d = 1'b1;
                    end
                end
                MODE_DRAW: begin
                    // renderComplete is not trusted in the drawline cycle:
                    // the renderer has not seen the start pulse yet.
                    if (!drawline_q && bus.renderComplete) begin
                        mode_d = MODE_HBLANK;
                    end else if (dot_d == DOT_DRAW_END) begin
                        mode_d           = MODE_HBLANK;
                        render_timeout_d = 1'b1;
                    end
                end
                default: begin
                    // HBlank and VBlank hold until the line wraps.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered status and pulses, all aligned with the new dot/ly
    // ------------------------------------------------------------------
    always_comb begin
        lyc_match_d  = bus.lcd_enable && (ly_d == bus.lyc);
        vblank_irq_d = bus.lcd_enable && running_q &&
                       (dot_d == 9'd0) && (ly_d == LY_VBLANK);
        frame_done_d = bus.lcd_enable && running_q &&
                       (dot_d == DOT_LAST) && (ly_d == LY_LAST);
    end

    // ------------------------------------------------------------------
    // STAT line and edge detect
    // ------------------------------------------------------------------
    always_comb begin
        stat_line = 1'b0;
        if (running_q) begin
            stat_line = (bus.stat_ie[0] && (mode_q == MODE_HBLANK)) ||
                        (bus.stat_ie[1] && (mode_q == MODE_VBLANK)) ||
                        (bus.stat_ie[2] && (mode_q == MODE_OAM))    ||
                        (bus.stat_ie[3] && lyc_match_q);
        end
        stat_line_d = bus.lcd_enable ? stat_line : 1'b0;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_q        <= 1'b0;
            dot_q            <= '0;
            ly_q             <= '0;
            mode_q           <= MODE_HBLANK;
            drawline_q       <= 1'b0;
            lyc_match_q      <= 1'b0;
            vblank_irq_q     <= 1'b0;
            frame_done_q     <= 1'b0;
            render_timeout_q <= 1'b0;
            stat_line_q      <= 1'b0;
        end else begin
            running_q        <= bus.lcd_enable;
            dot_q            <= dot_d;
            ly_q             <= ly_d;
            mode_q           <= mode_d;
            drawline_q       <= drawline_d;
            lyc_match_q      <= lyc_match_d;
            vblank_irq_q     <= vblank_irq_d;
            frame_done_q     <= frame_done_d;
            render_timeout_q <= render_timeout_d;
            stat_line_q      <= stat_line_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dot            = dot_q;
    assign bus.ly             = ly_q;
    assign bus.mode           = mode_q;
    assign bus.drawline       = drawline_q;
    assign bus.lyc_match      = lyc_match_q;
    assign bus.vblank_irq     = vblank_irq_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.render_timeout = render_timeout_q;
    assign bus.stat_irq       = stat_line & ~stat_line_q;

endmodule

// File: tb/tb_lcd_timing_controller.sv
// ----------------------------------------------------------------------------
// tb_lcd_timing_controller
//
// Drives the controller through reset, per-line render scenarios, LYC / STAT
// interrupt sequences, mid-line disable and a full randomised frame. A
// time-based reference model (dot/line derived from cycles since enable)
// predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_lcd_timing_controller;

    localparam int DPL    = 456;
    localparam int VIS    = 144;
    localparam int TOT    = 154;
    localparam int OAM    = 80;
    localparam int MAXD   = 289;
    localparam int TO_DOT = OAM + MAXD;
    localparam int NONE   = 999;

    logic clk = 1'b0;
    logic reset;

    lcd_timing_controller_if bus ();

    lcd_timing_controller #(
        .DOTS_PER_LINE (DPL),
        .LINES_VISIBLE (VIS),
        .LINES_TOTAL   (TOT),
        .OAM_DOTS      (OAM),
        .MAX_DRAW_DOTS (MAXD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Reference model: elapsed cycles since enable plus per-line end of
    // pixel transfer.
    // ------------------------------------------------------------------
    bit         m_act;
    int         m_t;
    int         m_end;   // first HBlank dot of the current line, 0 = not yet
    bit         m_to;
    bit         m_prev;  // STAT line level during the previous cycle
    logic [7:0] m_lyc;

    task automatic model_reset();
        m_act  = 1'b0;
        m_t    = 0;
        m_end  = 0;
        m_to   = 1'b0;
        m_prev = 1'b0;
        m_lyc  = 8'd0;
    endtask

    function automatic int e_dot();
        return m_act ? (m_t % DPL) : 0;
    endfunction

    function automatic int e_ly();
        return m_act ? ((m_t / DPL) % TOT) : 0;
    endfunction

    function automatic int e_mode();
        int d = e_dot();
        int l = e_ly();
        if (!m_act)                 return 0;
        if (l >= VIS)               return 1;
        if (d < OAM)                return 2;
        if (m_end == 0 || d < m_end) return 3;
        return 0;
    endfunction

    function automatic bit e_lycm();
        return m_act && (e_ly() == int'(m_lyc));
    endfunction

    function automatic bit e_line(input logic [3:0] ie);
        int md = e_mode();
        return m_act && ((ie[0] && md == 0) || (ie[1] && md == 1) ||
                         (ie[2] && md == 2) || (ie[3] && e_lycm()));
    endfunction

    function automatic logic [24:0] e_vec();
        int   d    = e_dot();
        int   l    = e_ly();
        int   md   = e_mode();
        logic line = e_line(bus.stat_ie);
        return {9'(d), 8'(l), 2'(md),
                m_act && l < VIS && d == OAM,
                e_lycm(),
                m_act && l == VIS && d == 0,
                line && !m_prev,
                m_act && l == TOT - 1 && d == DPL - 1,
                m_to};
    endfunction

    function automatic logic [24:0] a_vec();
        return {bus.dot, bus.ly, bus.mode, bus.drawline, bus.lyc_match,
                bus.vblank_irq, bus.stat_irq, bus.frame_done, bus.render_timeout};
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        logic line_b = e_line(bus.stat_ie);
        int   p;
        int   l;
        int   np;
        if (!bus.lcd_enable) begin
            m_act = 1'b0;
            m_t   = 0;
            m_end = 0;
        end else if (!m_act) begin
            m_act = 1'b1;
            m_t   = 0;
            m_end = 0;
        end else begin
            p = m_t % DPL;
            l = (m_t / DPL) % TOT;
            if (l < VIS && p > OAM && m_end == 0 && bus.renderComplete) m_end = p + 1;
            m_t++;
            np = m_t % DPL;
            if (np == 0) begin
                m_end = 0;
            end else if (l < VIS && np == TO_DOT && m_end == 0) begin
                m_to  = 1'b1;
                m_end = TO_DOT;
            end
        end
        m_prev = bus.lcd_enable && line_b;
        m_lyc  = bus.lyc;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (ly=%0d dot=%0d t=%0t)",
                     name, act, exp, bus.ly, bus.dot, $time);
            if (n_fail > 40) begin
                $display("End of test - %0d assertions evaluated, %0d failures",
                         n_checks, n_fail);
                $finish;
            end
        end
    endtask

    // Called at a falling edge with inputs applied for the coming rising edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("model", 32'(a_vec()), 32'(e_vec()));
    endtask

    // ------------------------------------------------------------------
    // Per-line render scenarios
    // ------------------------------------------------------------------
    typedef struct {
        int rc_a;     // dot at which renderComplete is high (NONE = never)
        int rc_b;
        int end_dot;  // first HBlank dot
        bit to;       // render_timeout at end of line
    } line_vec_t;

    line_vec_t tbl [6];

    int dl_cnt, irq_cnt, irq_at, m_in, m_out, win, hb;
    int vb_cnt, vb_k, fd_cnt, fd_k, m1;
    bit to_before;

    initial begin
        tbl[0] = '{252,  NONE, 253,    1'b0};
        tbl[1] = '{OAM,  150,  151,    1'b0};  // drawline-cycle pulse ignored
        tbl[2] = '{40,   81,   82,     1'b0};  // OAM-phase pulse ignored
        tbl[3] = '{368,  NONE, TO_DOT, 1'b0};
        tbl[4] = '{NONE, NONE, TO_DOT, 1'b1};  // timeout
        tbl[5] = '{100,  NONE, 101,    1'b1};  // timeout flag is sticky

        bus.lcd_enable     = 1'b0;
        bus.renderComplete = 1'b0;
        bus.lyc            = 8'd200;
        bus.stat_ie        = 4'hF;
        reset              = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 32'(a_vec()), 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        // Enable
        bus.lcd_enable = 1'b1;
        bus.stat_ie    = 4'h0;
        tick();
        check("enable_dot",  32'(bus.dot),  32'd0);
        check("enable_ly",   32'(bus.ly),   32'd0);
        check("enable_mode", 32'(bus.mode), 32'd2);

        // Table-driven lines
        for (int r = 0; r < 6; r++) begin
            dl_cnt = 0;
            for (int d = 0; d < DPL; d++) begin
                if (d == 0) begin
                    check("line_ly",         32'(bus.ly),   32'(r));
                    check("line_start_mode", 32'(bus.mode), 32'd2);
                end
                if (bus.drawline) dl_cnt++;
                if (d == OAM)
                    check("drawline_mode3", 32'({bus.drawline, bus.mode}), 32'h7);
                if (d == tbl[r].end_dot - 1)
                    check("mode3_last", 32'(bus.mode), 32'd3);
                if (d == tbl[r].end_dot)
                    check("mode0_first", 32'(bus.mode), 32'd0);
                if (d == DPL - 1) begin
                    check("timeout_flag",   32'(bus.render_timeout), 32'(tbl[r].to));
                    check("drawline_count", 32'(dl_cnt), 32'd1);
                end
                bus.renderComplete = (d == tbl[r].rc_a) || (d == tbl[r].rc_b);
                tick();
            end
        end

        // Asynchronous reset mid-frame
        bus.renderComplete = 1'b0;
        repeat (100) tick();
        #2 reset = 1'b1;
        #1 check("async_reset", 32'(a_vec()), 32'd0);
        model_reset();
        @(negedge clk);
        check("reset_held", 32'(a_vec()), 32'd0);
        reset = 1'b0;
        tick();
        check("post_reset_start", 32'({bus.ly, bus.mode, bus.dot}), 32'({8'd0, 2'd2, 9'd0}));

        // LYC=5, LYC interrupt only
        bus.lyc = 8'd5;
        bus.stat_ie = 4'b1000;
        bus.renderComplete = 1'b1;
        irq_cnt = 0; irq_at = 0; m_in = 0; m_out = 0;
        for (int k = 0; k < 7 * DPL; k++) begin
            if (bus.stat_irq) begin
                irq_cnt++;
                if (bus.ly == 8'd5 && bus.dot == 9'd0) irq_at++;
            end
            if (bus.lyc_match) begin
                if (bus.ly == 8'd5) m_in++;
                else m_out++;
            end
            tick();
        end
        check("lyc_irq_count", 32'(irq_cnt), 32'd1);
        check("lyc_irq_pos",   32'(irq_at),  32'd1);
        check("lyc_match_in",  32'(m_in),    32'(DPL));
        check("lyc_match_out", 32'(m_out),   32'd0);

        // HBlank of line 5 merges into LYC line 6
        bus.lcd_enable = 1'b0;
        tick();
        bus.lcd_enable = 1'b1;
        bus.lyc = 8'd6;
        bus.stat_ie = 4'b1001;
        tick();
        check("restart_mode", 32'(bus.mode), 32'd2);
        win = 0; hb = 0;
        for (int k = 0; k < 7 * DPL; k++) begin
            if (bus.stat_irq) begin
                if ((bus.ly == 8'd5 && bus.dot > 9'(OAM)) || bus.ly == 8'd6) win++;
                if (bus.ly == 8'd5 && bus.dot == 9'(OAM + 2)) hb++;
            end
            tick();
        end
        check("merged_irq_count", 32'(win), 32'd1);
        check("hblank_irq_pos",   32'(hb),  32'd1);

        // Disable mid pixel transfer
        bus.lcd_enable = 1'b0;
        tick();
        bus.lcd_enable = 1'b1;
        tick();
        bus.lyc = 8'($urandom_range(0, TOT - 1));
        bus.stat_ie = 4'($urandom);
        for (int k = 0; k < 10 * DPL + 150; k++) begin
            bus.renderComplete = (bus.ly != 8'd10) && ($urandom_range(0, 31) == 0);
            if (k % 997 == 0) bus.stat_ie = 4'($urandom);
            tick();
        end
        check("pre_drop_pos",  32'({bus.ly, bus.dot}), 32'({8'd10, 9'd150}));
        check("pre_drop_mode", 32'(bus.mode), 32'd3);
        to_before = m_to;
        bus.lcd_enable = 1'b0;
        bus.renderComplete = 1'b0;
        tick();
        check("drop_idle", 32'({bus.ly, bus.mode, bus.dot, bus.drawline}), 32'd0);
        check("drop_timeout_held", 32'(bus.render_timeout), 32'(to_before));
        bus.renderComplete = 1'b1;
        bus.stat_ie = 4'hF;
        repeat (5) tick();
        check("idle_quiet", 32'(a_vec() >> 1), 32'd0);
        bus.renderComplete = 1'b0;
        bus.lcd_enable = 1'b1;
        tick();
        check("reenable", 32'({bus.ly, bus.mode, bus.dot}), 32'({8'd0, 2'd2, 9'd0}));

        // Full randomised frame
        vb_cnt = 0; vb_k = -1; fd_cnt = 0; fd_k = -1; m1 = 0;
        for (int k = 0; k < TOT * DPL; k++) begin
            if (bus.vblank_irq) begin vb_cnt++; vb_k = k; end
            if (bus.frame_done) begin fd_cnt++; fd_k = k; end
            if (bus.mode == 2'd1) m1++;
            bus.renderComplete = ($urandom_range(0, 31) == 0);
            if (k % 1500 == 0) begin
                bus.stat_ie = 4'($urandom);
                bus.lyc = 8'($urandom_range(0, TOT - 1));
            end
            tick();
        end
        check("vblank_count",  32'(vb_cnt), 32'd1);
        check("vblank_cycle",  32'(vb_k),   32'(VIS * DPL));
        check("frame_count",   32'(fd_cnt), 32'd1);
        check("frame_cycle",   32'(fd_k),   32'(TOT * DPL - 1));
        check("mode1_cycles",  32'(m1),     32'((TOT - VIS) * DPL));
        check("frame_wrap", 32'({bus.ly, bus.mode, bus.dot}), 32'({8'd0, 2'd2, 9'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
